leve_alu_pipe: RTL and testbench
================================

Name: leve_alu_pipe

Overview:
Parametrised, pipelined integer ALU/branch unit for the LEVE core. It is the successor to the single-cycle adder ALU. It adds an opcode-selected operation set, branch and jump resolution, a destination-tag pass-through, valid/ready backpressure and a pipeline flush. It sits between operand read and register writeback / PC redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 5, width of the destination register index carried with each op.
STAGES, 2, pipeline depth; legal values 1 or 2. Latency equals STAGES.

Ports:
CLK  in  1  clock
RSTn  in  1  reset
IN_VALID  in  1  operation presented
IN_READY  out  1  unit accepts the op this cycle
OP  in  5  alu_op_e opcode
RS1_D  in  XLEN  operand 1
RS2_D  in  XLEN  operand 2
PC  in  XLEN  PC of the instruction
IMM  in  XLEN  sign-extended immediate
RD_IDX  in  TAG_W  destination tag
FLUSH  in  1  kill all in-flight ops
OUT_VALID  out  1  result valid
OUT_READY  in  1  consumer accepts the result
RD_WE  out  1  writeback enable; qualified by OUT_VALID
RD_IDX_O  out  TAG_W  destination tag of the result
RD_D  out  XLEN  writeback data
PC_BR  out  1  redirect taken
BR_TARGET  out  XLEN  redirect address
ALU_OUT  out  XLEN  raw ALU or compare result

Behaviour:
- Reset is RSTn, asynchronous, active-low; clock is CLK.
- Reset values: all stage valid bits 0, OUT_VALID 0, RD_WE 0, PC_BR 0. Data and tag registers are also cleared to 0, so no X appears on any output.
- Handshake: a transfer occurs when IN_VALID and IN_READY are both 1. Output is consumed when OUT_VALID and OUT_READY are both 1.
- IN_READY = OUT_READY or (any stage empty). Stage k advances when stage k+1 is empty or is itself advancing.
- No bubble is inserted at a sustained OUT_READY of 1: throughput is 1 op/cycle.
- While OUT_READY is 0, output registers hold and remain stable.
- Latency: an op accepted in cycle n appears at cycle n+STAGES when not stalled. In stage 1 operands/op are registered and computed. In stage 2 (if present) the result is registered.
- FLUSH: every stage valid bit is 0 at the next edge. An op offered in the FLUSH cycle is not accepted, and IN_READY is forced to 0 that cycle. FLUSH overrides a simultaneous output handshake, so the output is not counted as consumed.
- Ops and results:
  - ADD, SUB, AND, OR, XOR: RD_D = ALU_OUT = result mod 2^XLEN.
  - SLL, SRL, SRA: shift amount is RS2_D[$clog2(XLEN)-1:0]; SRA is arithmetic.
  - SLT, SLTU: ALU_OUT = 1 or 0, zero-extended.
  - For all of the above: RD_WE = 1, PC_BR = 0.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: RD_WE = 0, ALU_OUT = condition (0/1), PC_BR = condition, BR_TARGET = PC + IMM.
  - JAL: RD_WE = 1, RD_D = PC + 4, PC_BR = 1, BR_TARGET = PC + IMM.
  - JALR: as JAL, but BR_TARGET = (RS1_D + IMM) with bit 0 cleared.
  - Undefined OP: RD_WE = 0, PC_BR = 0, ALU_OUT = 0; no error signalled.
- When OUT_VALID is 0, RD_WE and PC_BR are driven 0.
- Wrap-around: PC + 4 and PC + IMM wrap modulo 2^XLEN.

Decomposition:
- Package leve_alu_pkg holds: typedef enum logic [4:0] alu_op_e (ADD=0, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR), the result struct typedef alu_res_t {we, br, tgt, d, tag}, and the function is_branch().
- One sub-module, leve_alu_core: purely combinational op -> alu_res_t. The top level holds the pipeline registers, the handshake and the flush logic.

Test Plan:
- Reset: hold RSTn=0 for 3 cycles with random inputs -> OUT_VALID=0, RD_WE=0, PC_BR=0, IN_READY=1 after release.
- Back-to-back ops, OUT_READY=1, STAGES=2: ADD 5+7, SUB 3-5, SRA 0x80000000 by 4 -> cycles n+2..n+4 give 12, 0xFFFFFFFE, 0xF8000000 with tags preserved.
- Branch: BLT, RS1=0xFFFFFFFF, RS2=1, PC=0x100, IMM=0x20 -> PC_BR=1, BR_TARGET=0x120, RD_WE=0. The same operands with BLTU -> PC_BR=0.
- JALR: RS1=0x1001, IMM=2, PC=0x200 -> RD_D=0x204, BR_TARGET=0x1002, PC_BR=1.
- Backpressure: OUT_READY=0 for 4 cycles while feeding 3 ops -> IN_READY drops after the pipe fills, outputs hold, and all 3 results emerge in order once OUT_READY=1.
- Flush: FLUSH with 2 ops in flight and a third offered -> OUT_VALID=0 next cycle; none of the 3 results is ever produced.

Source files
------------

// File: rtl/leve_alu_pipe_pkg.sv
// Shared types for the LEVE pipelined ALU/branch unit.
package leve_alu_pkg;

  // Result struct is sized for the widest legal datapath; narrower builds truncate.
  localparam int XLEN_MAX = 64;
  localparam int TAG_MAX  = 8;

  typedef enum logic [4:0] {
    ADD  = 5'd0,
    SUB  = 5'd1,
    AND  = 5'd2,
    OR   = 5'd3,
    XOR  = 5'd4,
    SLL  = 5'd5,
    SRL  = 5'd6,
    SRA  = 5'd7,
    SLT  = 5'd8,
    SLTU = 5'd9,
    BEQ  = 5'd10,
    BNE  = 5'd11,
    BLT  = 5'd12,
    BGE  = 5'd13,
    BLTU = 5'd14,
    BGEU = 5'd15,
    JAL  = 5'd16,
    JALR = 5'd17
  } alu_op_e;

  typedef struct packed {
    logic                we;
    logic                br;
    logic [XLEN_MAX-1:0] tgt;
    logic [XLEN_MAX-1:0] d;
    logic [TAG_MAX-1:0]  tag;
  } alu_res_t;

  // Conditional branches occupy a contiguous opcode range.
  function automatic logic is_branch(alu_op_e op);
    return (op >= BEQ) && (op <= BGEU);
  endfunction

endpackage

// File: rtl/leve_alu_pipe_if.sv
// Operand/result bus of the ALU pipe: issue side, flush and writeback/redirect side.
interface leve_alu_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             IN_VALID;
  logic             IN_READY;
  logic [4:0]       OP;
  logic [XLEN-1:0]  RS1_D;
  logic [XLEN-1:0]  RS2_D;
  logic [XLEN-1:0]  PC;
  logic [XLEN-1:0]  IMM;
  logic [TAG_W-1:0] RD_IDX;
  logic             FLUSH;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             RD_WE;
  logic [TAG_W-1:0] RD_IDX_O;
  logic [XLEN-1:0]  RD_D;
  logic             PC_BR;
  logic [XLEN-1:0]  BR_TARGET;
  logic [XLEN-1:0]  ALU_OUT;

  modport master (
    output IN_VALID, OP, RS1_D, RS2_D, PC, IMM, RD_IDX, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, RD_WE, RD_IDX_O, RD_D, PC_BR, BR_TARGET, ALU_OUT
  );

  modport slave (
    input  IN_VALID, OP, RS1_D, RS2_D, PC, IMM, RD_IDX, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, RD_WE, RD_IDX_O, RD_D, PC_BR, BR_TARGET, ALU_OUT
  );
endinterface

// File: rtl/leve_alu_pipe_core.sv
// Combinational op evaluation: opcode + operands -> writeback/redirect result.
module leve_alu_core
  import leve_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic [4:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [TAG_W-1:0] tag,
  output alu_res_t         res
);
  localparam int SHW = $clog2(XLEN);

  alu_op_e         opc;
  logic [SHW-1:0]  shamt;
  logic            lt, ltu, eq, cond;
  logic            we, br;
  logic [XLEN-1:0] d, tgt;

  assign opc   = alu_op_e'(op);
  assign shamt = rs2[SHW-1:0];
  assign lt    = $signed(rs1) < $signed(rs2);
  assign ltu   = rs1 < rs2;
  assign eq    = rs1 == rs2;

  // branch condition select
  always_comb begin
    cond = 1'b0;
    case (opc)
      BEQ:     cond = eq;
      BNE:     cond = !eq;
      BLT:     cond = lt;
      BGE:     cond = !lt;
      BLTU:    cond = ltu;
      BGEU:    cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  // result/writeback/redirect per opcode; unknown opcodes fall out as all-zero no-ops
  always_comb begin
    d   = '0;
    we  = 1'b0;
    br  = 1'b0;
    tgt = pc + imm;
    if (is_branch(opc)) begin
      d  = XLEN'(cond);
      br = cond;
    end else begin
      case (opc)
        ADD:  begin d = rs1 + rs2;                   we = 1'b1; end
        SUB:  begin d = rs1 - rs2;                   we = 1'b1; end
        AND:  begin d = rs1 & rs2;                   we = 1'b1; end
        OR:   begin d = rs1 | rs2;                   we = 1'b1; end
        XOR:  begin d = rs1 ^ rs2;                   we = 1'b1; end
        SLL:  begin d = rs1 << shamt;                we = 1'b1; end
        SRL:  begin d = rs1 >> shamt;                we = 1'b1; end
        SRA:  begin d = $signed(rs1) >>> shamt;      we = 1'b1; end
        SLT:  begin d = XLEN'(lt);                   we = 1'b1; end
        SLTU: begin d = XLEN'(ltu);                  we = 1'b1; end
        JAL:  begin d = pc + XLEN'(4); we = 1'b1; br = 1'b1; end
        JALR: begin
          d   = pc + XLEN'(4);
          we  = 1'b1;
          br  = 1'b1;
          tgt = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign res = '{we: we, br: br, tgt: XLEN_MAX'(tgt), d: XLEN_MAX'(d), tag: TAG_MAX'(tag)};

endmodule

// File: rtl/leve_alu_pipe.sv
// Pipelined ALU/branch unit: operand register stage, optional result stage,
// valid/ready backpressure and a flush that empties every stage.
module leve_alu_pipe
  import leve_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2
) (
  input logic            CLK,
  input logic            RSTn,
  leve_alu_pipe_if.slave bus
);
  logic [STAGES:1]  vld_pipe;
  logic [STAGES:1]  adv;
  logic             in_fire;

  logic [4:0]       op_q;
  logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, imm_q;
  logic [TAG_W-1:0] tag_q;

  alu_res_t         core_res;
  alu_res_t         out_res;
  logic             unused_res;

  // stall chain from the output back: a stage moves if the next is empty or moving
  always_comb begin
    logic go;
    go = !vld_pipe[STAGES] || bus.OUT_READY;
    adv = '0;
    adv[STAGES] = go;
    for (int k = STAGES - 1; k >= 1; k--) begin
      go     = !vld_pipe[k] || go;
      adv[k] = go;
    end
  end

  assign bus.IN_READY = adv[1] && !bus.FLUSH;
  assign in_fire      = bus.IN_VALID && bus.IN_READY;

  // stage valid bits; flush wins over any handshake
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_pipe <= '0;
    end else if (bus.FLUSH) begin
      vld_pipe <= '0;
    end else begin
      if (adv[1]) vld_pipe[1] <= in_fire;
      for (int k = 2; k <= STAGES; k++)
        if (adv[k]) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // operand/op capture on accept
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      pc_q  <= '0;
      imm_q <= '0;
      tag_q <= '0;
    end else if (in_fire) begin
      op_q  <= bus.OP;
      rs1_q <= bus.RS1_D;
      rs2_q <= bus.RS2_D;
      pc_q  <= bus.PC;
      imm_q <= bus.IMM;
      tag_q <= bus.RD_IDX;
    end
  end

  leve_alu_core #(.XLEN(XLEN), .TAG_W(TAG_W)) u_core (
    .op  (op_q),
    .rs1 (rs1_q),
    .rs2 (rs2_q),
    .pc  (pc_q),
    .imm (imm_q),
    .tag (tag_q),
    .res (core_res)
  );

  generate
    if (STAGES == 2) begin : g_s2
      alu_res_t res_q;
      // result register; holds while the consumer stalls
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)                      res_q <= '0;
        else if (adv[2] && vld_pipe[1]) res_q <= core_res;
      end
      assign out_res = res_q;
    end else begin : g_s1
      assign out_res = core_res;
    end
  endgenerate

  assign bus.OUT_VALID = vld_pipe[STAGES];
  assign bus.RD_WE     = vld_pipe[STAGES] && out_res.we;
  assign bus.PC_BR     = vld_pipe[STAGES] && out_res.br;
  assign bus.RD_D      = out_res.d[XLEN-1:0];
  assign bus.ALU_OUT   = out_res.d[XLEN-1:0];
  assign bus.BR_TARGET = out_res.tgt[XLEN-1:0];
  assign bus.RD_IDX_O  = out_res.tag[TAG_W-1:0];

  // upper struct bits exist only for the widest build
  assign unused_res = ^{out_res.tgt, out_res.d, out_res.tag};

endmodule

// File: tb/tb_leve_alu_pipe.sv
// Self-checking bench for leve_alu_pipe: directed table, random vs. model, stall and flush sequences.
module tb_leve_alu_pipe;
  import leve_alu_pkg::*;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 5;
  localparam int STAGES = 2;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  leve_alu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  leve_alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] d;
    logic        we;
    logic        br;
    logic [31:0] tgt;
    logic [4:0]  tag;
    logic        chk_alu;
    logic        lat;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, pc, imm;
    logic [4:0]  tag;
    logic [31:0] d;
    logic        we, br;
    logic [31:0] tgt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, b, pc, imm,
                              input logic [4:0] tag, input logic [31:0] d,
                              input logic we, br, input logic [31:0] tgt);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.pc = pc; v.imm = imm; v.tag = tag;
    v.d = d; v.we = we; v.br = br; v.tgt = tgt;
    return v;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.d = v.d; e.we = v.we; e.br = v.br; e.tgt = v.tgt; e.tag = v.tag;
    e.chk_alu = !(v.op == JAL || v.op == JALR);
    e.lat = 1'b0; e.cyc = 0;
    return e;
  endfunction

  // Reference model straight from the opcode definitions.
  function automatic exp_t model(input vec_t v);
    exp_t        e;
    int unsigned sh;
    logic        c;
    sh = v.b % 32;
    c  = 1'b0;
    e.d = 32'h0; e.we = 1'b0; e.br = 1'b0; e.tgt = v.pc + v.imm; e.tag = v.tag;
    e.chk_alu = 1'b1; e.lat = 1'b0; e.cyc = 0;
    case (alu_op_e'(v.op))
      ADD:  begin e.d = v.a + v.b; e.we = 1'b1; end
      SUB:  begin e.d = v.a - v.b; e.we = 1'b1; end
      AND:  begin e.d = v.a & v.b; e.we = 1'b1; end
      OR:   begin e.d = v.a | v.b; e.we = 1'b1; end
      XOR:  begin e.d = v.a ^ v.b; e.we = 1'b1; end
      SLL:  begin e.d = v.a << sh; e.we = 1'b1; end
      SRL:  begin e.d = v.a >> sh; e.we = 1'b1; end
      SRA:  begin
        e.d  = (v.a >> sh) | (v.a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        e.we = 1'b1;
      end
      SLT:  begin e.d = {31'd0, $signed(v.a) < $signed(v.b)}; e.we = 1'b1; end
      SLTU: begin e.d = {31'd0, v.a < v.b}; e.we = 1'b1; end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        case (alu_op_e'(v.op))
          BEQ:     c = (v.a == v.b);
          BNE:     c = (v.a != v.b);
          BLT:     c = ($signed(v.a) < $signed(v.b));
          BGE:     c = ($signed(v.a) >= $signed(v.b));
          BLTU:    c = (v.a < v.b);
          default: c = (v.a >= v.b);
        endcase
        e.d = {31'd0, c}; e.br = c;
      end
      JAL:  begin e.d = v.pc + 4; e.we = 1'b1; e.br = 1'b1; e.chk_alu = 1'b0; end
      JALR: begin
        e.d = v.pc + 4; e.we = 1'b1; e.br = 1'b1; e.chk_alu = 1'b0;
        e.tgt = (v.a + v.imm) & 32'hFFFF_FFFE;
      end
      default: ;
    endcase
    return e;
  endfunction

  // One cycle: drive at negedge, evaluate both handshakes 1ns later.
  task automatic step(input logic iv, input vec_t v, input logic ordy, input logic fl,
                      input logic lat, input exp_t e_in, output logic acc);
    exp_t e;
    @(negedge CLK);
    bus.IN_VALID = iv;  bus.OP = v.op;  bus.RS1_D = v.a;  bus.RS2_D = v.b;
    bus.PC = v.pc;      bus.IMM = v.imm; bus.RD_IDX = v.tag;
    bus.OUT_READY = ordy; bus.FLUSH = fl;
    #1;
    if (bus.OUT_VALID && ordy && !fl) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(bus.RD_IDX_O), 64'h1_0000);
      end else begin
        e = sb.pop_front();
        chk("rd_d", 64'(bus.RD_D), 64'(e.d));
        chk("rd_we", 64'(bus.RD_WE), 64'(e.we));
        chk("pc_br", 64'(bus.PC_BR), 64'(e.br));
        chk("rd_idx_o", 64'(bus.RD_IDX_O), 64'(e.tag));
        if (e.br)      chk("br_target", 64'(bus.BR_TARGET), 64'(e.tgt));
        if (e.chk_alu) chk("alu_out", 64'(bus.ALU_OUT), 64'(e.d));
        if (e.lat)     chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
      end
    end else if (!bus.OUT_VALID) begin
      chk("idle_rd_we", 64'(bus.RD_WE), 64'h0);
      chk("idle_pc_br", 64'(bus.PC_BR), 64'h0);
    end
    acc = iv && bus.IN_READY;
    if (acc) begin
      e = e_in; e.cyc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    if (fl) sb.delete();
    cyc++;
  endtask

  task automatic drain();
    vec_t idle;
    exp_t e0;
    logic acc;
    idle = mk(5'd0, 0, 0, 0, 0, 5'd0, 0, 1'b0, 1'b0, 0);
    e0   = from_vec(idle);
    for (int i = 0; i < 12 && sb.size() > 0; i++)
      step(1'b0, idle, 1'b1, 1'b0, 1'b0, e0, acc);
    chk("drain_empty", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, va, vb, vc;
    exp_t e0;
    logic acc, iv, ordy, fl;

    // reset held 3 cycles with random inputs
    repeat (3) begin
      @(negedge CLK);
      bus.IN_VALID = 1'b1; bus.OP = 5'($urandom); bus.RS1_D = $urandom; bus.RS2_D = $urandom;
      bus.PC = $urandom; bus.IMM = $urandom; bus.RD_IDX = 5'($urandom);
      bus.OUT_READY = 1'($urandom); bus.FLUSH = 1'($urandom);
      #1;
      chk("rst_out_valid", 64'(bus.OUT_VALID), 64'h0);
      chk("rst_rd_we", 64'(bus.RD_WE), 64'h0);
      chk("rst_pc_br", 64'(bus.PC_BR), 64'h0);
    end
    @(negedge CLK);
    RSTn = 1'b1; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0; bus.FLUSH = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.IN_READY), 64'h1);
    chk("rst_out_valid_rel", 64'(bus.OUT_VALID), 64'h0);

    // directed table, back-to-back with OUT_READY=1
    tbl.push_back(mk(ADD,  32'd5,         32'd7,  32'h0,        32'h0,        5'd1,  32'd12,        1, 0, 32'h0));
    tbl.push_back(mk(SUB,  32'd3,         32'd5,  32'h0,        32'h0,        5'd2,  32'hFFFF_FFFE, 1, 0, 32'h0));
    tbl.push_back(mk(SRA,  32'h8000_0000, 32'd4,  32'h0,        32'h0,        5'd3,  32'hF800_0000, 1, 0, 32'h0));
    tbl.push_back(mk(BLT,  32'hFFFF_FFFF, 32'd1,  32'h100,      32'h20,       5'd4,  32'd1,         0, 1, 32'h120));
    tbl.push_back(mk(BLTU, 32'hFFFF_FFFF, 32'd1,  32'h100,      32'h20,       5'd5,  32'd0,         0, 0, 32'h0));
    tbl.push_back(mk(JALR, 32'h1001,      32'd0,  32'h200,      32'h2,        5'd6,  32'h204,       1, 1, 32'h1002));
    tbl.push_back(mk(JAL,  32'h0,         32'd0,  32'hFFFF_FFFC, 32'h8,       5'd7,  32'h0,         1, 1, 32'h4));
    tbl.push_back(mk(SLT,  32'hFFFF_FFFF, 32'd1,  32'h0,        32'h0,        5'd8,  32'd1,         1, 0, 32'h0));
    tbl.push_back(mk(SLTU, 32'hFFFF_FFFF, 32'd1,  32'h0,        32'h0,        5'd9,  32'd0,         1, 0, 32'h0));
    tbl.push_back(mk(SLL,  32'd1,         32'd35, 32'h0,        32'h0,        5'd10, 32'd8,         1, 0, 32'h0));
    tbl.push_back(mk(SRL,  32'h8000_0000, 32'd4,  32'h0,        32'h0,        5'd11, 32'h0800_0000, 1, 0, 32'h0));
    tbl.push_back(mk(AND,  32'hF0F0,      32'hFF00, 32'h0,      32'h0,        5'd12, 32'hF000,      1, 0, 32'h0));
    tbl.push_back(mk(OR,   32'hF0F0,      32'hFF00, 32'h0,      32'h0,        5'd13, 32'hFFF0,      1, 0, 32'h0));
    tbl.push_back(mk(XOR,  32'hF0F0,      32'hFF00, 32'h0,      32'h0,        5'd14, 32'h0FF0,      1, 0, 32'h0));
    tbl.push_back(mk(BEQ,  32'd7,         32'd7,  32'h10,       32'hFFFF_FFF0, 5'd15, 32'd1,        0, 1, 32'h0));
    tbl.push_back(mk(BNE,  32'd5,         32'd5,  32'h10,       32'h4,        5'd16, 32'd0,         0, 0, 32'h0));
    tbl.push_back(mk(BGE,  32'hFFFF_FFFF, 32'd1,  32'h10,       32'h4,        5'd17, 32'd0,         0, 0, 32'h0));
    tbl.push_back(mk(BGEU, 32'hFFFF_FFFF, 32'd1,  32'h300,      32'h40,       5'd18, 32'd1,         0, 1, 32'h340));
    tbl.push_back(mk(5'd31, 32'd9,        32'd9,  32'h10,       32'h4,        5'd19, 32'd0,         0, 0, 32'h0));
    foreach (tbl[i]) begin
      step(1'b1, tbl[i], 1'b1, 1'b0, 1'b1, from_vec(tbl[i]), acc);
      chk("tbl_accept", 64'(acc), 64'h1);
    end
    drain();

    // random traffic with stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      v.op  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      v.a   = $urandom;
      v.b   = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
      v.pc  = $urandom;
      v.imm = $urandom;
      v.tag = 5'($urandom);
      v.d = 0; v.we = 0; v.br = 0; v.tgt = 0;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      step(iv, v, ordy, fl, 1'b0, model(v), acc);
    end
    drain();

    // backpressure: OUT_READY low for 4 cycles while 3 ops are offered
    va = mk(ADD, 32'd1, 32'd1, 0, 0, 5'd10, 32'd2, 1, 0, 0);
    vb = mk(ADD, 32'd2, 32'd2, 0, 0, 5'd11, 32'd4, 1, 0, 0);
    vc = mk(XOR, 32'd6, 32'd3, 0, 0, 5'd12, 32'd5, 1, 0, 0);
    step(1'b1, va, 1'b0, 1'b0, 1'b0, from_vec(va), acc);
    chk("bp_acc1", 64'(acc), 64'h1);
    step(1'b1, vb, 1'b0, 1'b0, 1'b0, from_vec(vb), acc);
    chk("bp_acc2", 64'(acc), 64'h1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, vc, 1'b0, 1'b0, 1'b0, from_vec(vc), acc);
      chk("bp_in_ready_low", 64'(bus.IN_READY), 64'h0);
      chk("bp_out_valid", 64'(bus.OUT_VALID), 64'h1);
      chk("bp_hold_data", 64'(bus.ALU_OUT), 64'h2);
      chk("bp_hold_tag", 64'(bus.RD_IDX_O), 64'd10);
    end
    step(1'b1, vc, 1'b1, 1'b0, 1'b0, from_vec(vc), acc);
    chk("bp_acc3", 64'(acc), 64'h1);
    drain();

    // flush with two ops in flight and a third offered
    va = mk(SUB, 32'd9, 32'd1, 0, 0, 5'd20, 32'd8, 1, 0, 0);
    vb = mk(ADD, 32'd9, 32'd1, 0, 0, 5'd21, 32'd10, 1, 0, 0);
    vc = mk(OR,  32'd9, 32'd1, 0, 0, 5'd22, 32'd9, 1, 0, 0);
    step(1'b1, va, 1'b1, 1'b0, 1'b0, from_vec(va), acc);
    chk("fl_accA", 64'(acc), 64'h1);
    step(1'b1, vb, 1'b1, 1'b0, 1'b0, from_vec(vb), acc);
    chk("fl_accB", 64'(acc), 64'h1);
    step(1'b1, vc, 1'b1, 1'b1, 1'b0, from_vec(vc), acc);
    chk("fl_in_ready", 64'(bus.IN_READY), 64'h0);
    e0 = from_vec(vc);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, vc, 1'b1, 1'b0, 1'b0, e0, acc);
      chk("fl_out_valid", 64'(bus.OUT_VALID), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
